// File: rtl/vga_timing_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_timing_pkg                                                           |
// | 640x480@60 raster defaults, derived totals and a counter-width helper.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_timing_pkg;

  localparam int   DEF_H_ACTIVE = 640;
  localparam int   DEF_H_FP     = 16;
  localparam int   DEF_H_SYNC   = 96;
  localparam int   DEF_H_BP     = 48;
  localparam int   DEF_V_ACTIVE = 480;
  localparam int   DEF_V_FP     = 10;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BP     = 33;
  localparam logic DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Bits needed to hold the values 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic frame_start;
    logic line_end;
  } vga_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_mod_counter.sv
// +--------------------------------------------------------------------------+
// | mod_counter                                                              |
// | Modulo-MOD up counter with increment strobe and wrap indication.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int MOD = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_sclr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  if (MOD < 2 || W < cnt_width(MOD)) begin : g_bad_cfg
    $error("mod_counter: MOD must be >= 2 and W wide enough for MOD-1");
  end

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_sclr) begin
      cnt_d = '0;
    end else if (i_inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_wrap = i_inc & (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +--------------------------------------------------------------------------+
// | vga_timing_gen                                                           |
// | VGA raster timing (sync, DE, coordinates) advanced by a pixel enable.    |
// | Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter output.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   XW       = 10,
  parameter int   YW       = 10
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_sclr,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_line_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]    o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SS_X   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE_X   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] H_LAST_X = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SS_Y   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE_Y   = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_ctrl_t CTRL_RST = '{1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0};

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  if (XW < cnt_width(H_TOTAL) || YW < cnt_width(V_TOTAL)) begin : g_bad_width
    $error("vga_timing_gen: XW/YW too small for H_TOTAL-1/V_TOTAL-1");
  end

  logic [XW-1:0] w_hc;
  logic [YW-1:0] w_vc;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_at_origin;

  mod_counter #(.MOD(H_TOTAL), .W(XW)) u_hcnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_sclr  (i_sclr),
    .i_inc   (i_en),
    .o_cnt   (w_hc),
    .o_wrap  (w_h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(YW)) u_vcnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_sclr  (i_sclr),
    .i_inc   (w_h_wrap & i_en),
    .o_cnt   (w_vc),
    .o_wrap  (w_v_wrap)
  );

  assign w_at_origin = (w_hc == '0) && (w_vc == '0);

  vga_ctrl_t     ctrl_q, ctrl_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Outputs show the decode of the count before it advances; pulses self-clear.
  always_comb begin
    ctrl_d             = ctrl_q;
    ctrl_d.frame_start = 1'b0;
    ctrl_d.line_end    = 1'b0;
    x_d                = x_q;
    y_d                = y_q;
    if (i_sclr) begin
      ctrl_d = CTRL_RST;
      x_d    = '0;
      y_d    = '0;
    end else if (i_en) begin
      ctrl_d.de          = (w_hc < H_ACT_X) && (w_vc < V_ACT_Y);
      ctrl_d.hsync       = ((w_hc >= H_SS_X) && (w_hc < H_SE_X)) ? SYNC_POL : ~SYNC_POL;
      ctrl_d.vsync       = ((w_vc >= V_SS_Y) && (w_vc < V_SE_Y)) ? SYNC_POL : ~SYNC_POL;
      ctrl_d.frame_start = w_at_origin;
      ctrl_d.line_end    = (w_hc == H_LAST_X);
      x_d                = w_hc;
      y_d                = w_vc;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q <= CTRL_RST;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign o_de          = ctrl_q.de;
  assign o_hsync       = ctrl_q.hsync;
  assign o_vsync       = ctrl_q.vsync;
  assign o_frame_start = ctrl_q.frame_start;
  assign o_line_end    = ctrl_q.line_end;
  assign o_x           = x_q;
  assign o_y           = y_q;

`ifdef VGA_FRAME_CNT_EN
  // A frame start counts only once a full frame has wrapped since reset/clear.
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       wrapped_q, wrapped_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    wrapped_d   = wrapped_q;
    if (i_sclr) begin
      frame_cnt_d = '0;
      wrapped_d   = 1'b0;
    end else begin
      if (w_v_wrap) begin
        wrapped_d = 1'b1;
      end
      if (i_en && w_at_origin && wrapped_q) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the periodic pixel-enable strobe produced by the enable generator and turns it into VGA raster timing.
- Generates hsync, vsync, data-enable and the pixel coordinates used by the pixel pipeline.
- Horizontal and vertical counters advance only on clock edges where i_en=1, so pixel rate = clk rate / enable period.
- Sits between the enable generator and the pixel source / VGA output pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of o_hsync/o_vsync (0 = active-low)
- XW / YW, 10 / 10, widths of o_x / o_y; must hold H_TOTAL-1 / V_TOTAL-1

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sclr  in  1  synchronous clear; same effect as reset, with priority over i_en
- i_en  in  1  pixel enable strobe from the enable generator
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  high while the pixel is in the active area
- o_x  out  XW  current horizontal count, 0..H_TOTAL-1
- o_y  out  YW  current line count, 0..V_TOTAL-1
- o_frame_start  out  1  one-clk pulse when pixel (0,0) is presented
- o_line_end  out  1  one-clk pulse when the last pixel of any line is presented

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined likewise.
- Internal counters hc and vc reset to 0.
- On a clk edge with i_en=1:
  - all outputs register the decode of the pre-advance (hc,vc);
  - hc increments.
- When hc == H_TOTAL-1 on an enable edge:
  - hc wraps to 0;
  - vc increments, or wraps to 0 when vc == V_TOTAL-1.
- Decode:
  - de = (hc < H_ACTIVE) and (vc < V_ACTIVE);
  - hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC;
  - vsync asserted for V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, for whole lines;
  - o_x = hc, o_y = vc.
- Registered outputs hold their value between enable edges. Latency is one clk from the enable edge to a valid output.
- Pulses:
  - o_frame_start = 1 for exactly one clk, following the enable edge that loads (0,0);
  - o_line_end = 1 for exactly one clk, following the enable edge that loads hc = H_TOTAL-1.
  - Both pulses are 0 on every other cycle, including idle cycles with i_en=0.
- Reset / clear values:
  - o_de = 0, o_x = 0, o_y = 0, pulses = 0;
  - o_hsync = o_vsync = ~SYNC_POL (inactive).
- Reset or clear asserted mid-frame abandons the frame. The first enable edge afterwards presents (0,0) with o_frame_start.
- i_sclr and i_en in the same cycle: the clear wins and counters do not advance.
- i_en held high continuously (enable period 1) is legal: one pixel per clk.
- Elaboration check: if any porch or sync width is 0, or a counter width is too small, issue $error.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - adds output o_frame_cnt [7:0];
  - resets/clears to 0;
  - increments on the same enable edge that raises o_frame_start, except the first one after reset or clear;
  - wraps 255->0.
- Undefined: no port, no logic.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 constants (H_*/V_* defaults, SYNC_POL);
  - the derived H_TOTAL/V_TOTAL;
  - a clog2-based width helper.
- Sub-module: mod_counter (parameter MOD, width W).
  - Inputs: clk, i_rst_n, i_sclr, i_inc. Outputs: o_cnt, o_wrap.
  - Instantiated twice: the h counter uses i_inc = i_en; the v counter uses i_inc = h o_wrap & i_en.

Test Plan:
All scenarios use small timing: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), SYNC_POL=0, with i_en from an enable generator of BIT_SIZE=1 (pulse every 2 clks).
- Reset then release -> o_de=0, o_hsync=o_vsync=1, o_x=o_y=0. The first enable edge gives o_de=1, (0,0), o_frame_start=1 for 1 clk only.
- One full line -> o_de=1 for x=0..3 and 0 for x=4..7. o_hsync=0 exactly for x=5,6. o_line_end pulses once at x=7. The next pixel is (0,1).
- Full frame -> o_vsync=0 for all pixels of y=4 only. o_de=0 on lines 3..5. After (7,5) the next pixel is (0,0) with o_frame_start; 48 enable edges per frame.
- Assert i_sclr concurrently with i_en at (3,2) -> the clear wins. Outputs return to reset values, and the next enable presents (0,0) with o_frame_start.
- Drop i_rst_n asynchronously mid-line (no clk edge) -> outputs go to reset values immediately.
- With VGA_FRAME_CNT_EN: run 3 frames -> o_frame_cnt reads 0, 1, 2 at successive frame starts. Force 255 frames -> wraps to 0.
